// File: rtl/rodada_jogo.sv
// Round engine for the LED-memory game.
// Plays back a stored sequence of N-bit LED patterns with fixed on/off timing. It then
// takes one button press per step and compares it exactly against the stored pattern.
// It counts hits, limits the time allowed per move, and ends the round as hit, miss or
// timeout.
//
// Ports:
//   clock, reset        single clock domain; synchronous active-high reset
//   wr_en/wr_addr/...   pattern memory write port (only honoured while idle)
//   comprimento         sequence length, latched when a round starts
//   iniciar             start request (level, sampled every cycle)
//   botoes              raw button levels
//   leds                LED drive
//   jogando, pronto     player-input phase / round finished
//   acertou/errou/timeout  round outcome, exactly one high in FIM
//   acertos             correct moves this round
//   db_estado           current state encoding, for debug
module rodada_jogo #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned T_ON     = 500,
  parameter int unsigned T_OFF    = 500,
  parameter int unsigned T_JOGADA = 3000,
  parameter int unsigned TW       = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW:0]   comprimento,
  input  logic          iniciar,
  input  logic [N-1:0]  botoes,
  output logic [N-1:0]  leds,
  output logic          jogando,
  output logic          pronto,
  output logic          acertou,
  output logic          errou,
  output logic          timeout,
  output logic [AW:0]   acertos,
  output logic [2:0]    db_estado
);

  typedef enum logic [2:0] {
    Ocioso    = 3'd0,
    MostraOn  = 3'd1,
    MostraOff = 3'd2,
    Espera    = 3'd3,
    Compara   = 3'd4,
    Fim       = 3'd5
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   acertos_q, acertos_d;
  logic [N-1:0]  jogada_q, jogada_d;
  logic          acertou_q, acertou_d;
  logic          errou_q, errou_d;
  logic          timeout_q, timeout_d;
  logic          any_q;

  logic [N-1:0] mem [DEPTH];

  logic any_now, move, start_ok, fim_seq, mem_wr;

  assign any_now  = |botoes;
  // A move is the rising edge of any button; any_q tracks the level in every state,
  // so a button already held when ESPERA is entered never counts as a move.
  assign move     = any_now & ~any_q;
  assign start_ok = iniciar && (comprimento != '0) && (comprimento <= (AW+1)'(DEPTH));
  assign fim_seq  = (({1'b0, idx_q} + 1'b1) == len_q);
  assign mem_wr   = wr_en && (estado_q == Ocioso) && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  // Pattern memory is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= Ocioso;
      timer_q   <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      acertos_q <= '0;
      jogada_q  <= '0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      acertos_q <= acertos_d;
      jogada_q  <= jogada_d;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      timeout_q <= timeout_d;
      any_q     <= any_now;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q + 1'b1;
    idx_d     = idx_q;
    len_d     = len_q;
    acertos_d = acertos_q;
    jogada_d  = jogada_q;
    acertou_d = acertou_q;
    errou_d   = errou_q;
    timeout_d = timeout_q;
    leds      = '0;

    case (estado_q)
      Ocioso, Fim: begin
        timer_d = '0;
        if (start_ok) begin
          len_d     = comprimento;
          idx_d     = '0;
          acertos_d = '0;
          acertou_d = 1'b0;
          errou_d   = 1'b0;
          timeout_d = 1'b0;
          estado_d  = MostraOn;
        end
      end
      MostraOn: begin
        leds = mem[idx_q];
        if (timer_q == TW'(T_ON - 1)) begin
          estado_d = MostraOff;
        end
      end
      MostraOff: begin
        if (timer_q == TW'(T_OFF - 1)) begin
          if (fim_seq) begin
            idx_d    = '0;
            estado_d = Espera;
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = MostraOn;
          end
        end
      end
      Espera: begin
        // A move in the expiry cycle still wins over the timeout.
        if (move) begin
          jogada_d = botoes;
          estado_d = Compara;
        end else if (timer_q == TW'(T_JOGADA - 1)) begin
          timeout_d = 1'b1;
          estado_d  = Fim;
        end
      end
      Compara: begin
        if (jogada_q == mem[idx_q]) begin
          acertos_d = acertos_q + 1'b1;
          if (fim_seq) begin
            idx_d     = '0;
            acertou_d = 1'b1;
            estado_d  = Fim;
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = Espera;
          end
        end else begin
          errou_d  = 1'b1;
          estado_d = Fim;
        end
      end
      default: begin
        estado_d = Ocioso;
      end
    endcase

    // Every state change restarts the shared timer.
    if (estado_d != estado_q) begin
      timer_d = '0;
    end
  end

  assign jogando   = (estado_q == Espera) || (estado_q == Compara);
  assign pronto    = (estado_q == Fim);
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign timeout   = timeout_q;
  assign acertos   = acertos_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_rodada_jogo.sv
// Self-checking bench for rodada_jogo. Stimulus pushes the expected outcome of every
// state transition (state, outputs, and how many cycles the previous state lasted) into
// a queue. A monitor pops one entry whenever db_estado changes and compares it.
module tb_rodada_jogo;

  localparam int unsigned AW = 4;

  logic          clock;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [AW:0]   comprimento;
  logic          iniciar;
  logic [3:0]    botoes;
  logic [3:0]    leds;
  logic          jogando, pronto, acertou, errou, timeout;
  logic [AW:0]   acertos;
  logic [2:0]    db_estado;

  rodada_jogo dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .comprimento (comprimento),
    .iniciar     (iniciar),
    .botoes      (botoes),
    .leds        (leds),
    .jogando     (jogando),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .timeout     (timeout),
    .acertos     (acertos),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    logic [3:0] leds;
    logic [4:0] acertos;
    logic       jog, pr, ac, er, to;
    int         dwell; // cycles spent in the previous state; -1 = don't care
  } obs_t;

  obs_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic       done = 1'b0;
  logic [3:0] pat [16];

  task automatic expect_ev(input logic [2:0] st, input logic [3:0] l, input logic [4:0] ac,
                           input logic hit, input logic miss, input logic tmo,
                           input int dwell);
    obs_t o;
    o.st      = st;
    o.leds    = l;
    o.acertos = ac;
    o.jog     = (st == 3'd3) || (st == 3'd4);
    o.pr      = (st == 3'd5);
    o.ac      = hit;
    o.er      = miss;
    o.to      = tmo;
    o.dwell   = dwell;
    q.push_back(o);
  endtask

  task automatic expect_playback(input int len, input int first_dwell);
    for (int i = 0; i < len; i++) begin
      expect_ev(3'd1, pat[i], 5'd0, 1'b0, 1'b0, 1'b0, (i == 0) ? first_dwell : 500);
      expect_ev(3'd2, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 500);
    end
    expect_ev(3'd3, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 500);
  endtask

  task automatic start(input logic [4:0] len);
    @(negedge clock);
    comprimento = len;
    iniciar     = 1'b1;
    @(negedge clock);
    iniciar     = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (db_estado != s && n < 20000);
    if (db_estado != s) begin
      $display("FAIL wait_state: state=%0d, required %0d within 20000 cycles", db_estado, s);
      $fatal(1);
    end
  endtask

  task automatic press(input logic [3:0] p);
    botoes = p;
    repeat (5) @(negedge clock);
    botoes = 4'd0;
    repeat (5) @(negedge clock);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    comprimento = '0; iniciar = 1'b0; botoes = '0;
    expect_ev(3'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pat[0] = 4'd1; pat[1] = 4'd2; pat[2] = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat[i];
    end
    @(negedge clock);
    wr_en = 1'b0;

    // Round 1: correct 1,2,4 -> acertou
    expect_playback(3, -1);
    start(5'd3);
    wait_state(3'd3);
    expect_ev(3'd4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1);
    expect_ev(3'd3, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1);
    press(4'd1);
    expect_ev(3'd4, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd3, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1);
    press(4'd2);
    expect_ev(3'd4, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd5, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1);
    press(4'd4);

    // Round 2 (restart from FIM): write attempt in ESPERA, then 1 then 8 -> errou
    expect_playback(3, -1);
    start(5'd3);
    wait_state(3'd3);
    wr_en = 1'b1; wr_addr = '0; wr_data = 4'd8;
    @(negedge clock);
    wr_en = 1'b0;
    expect_ev(3'd4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2);
    expect_ev(3'd3, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1);
    press(4'd1);
    expect_ev(3'd4, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd5, 4'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1);
    press(4'd8);

    // Round 3: no press -> timeout after exactly 3000 cycles (mem[0] must still be 1)
    expect_playback(3, -1);
    expect_ev(3'd5, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3000);
    start(5'd3);
    wait_state(3'd3);
    wait_state(3'd5);

    // Round 4: press lands in the last allowed cycle -> compare proceeds
    expect_playback(3, -1);
    start(5'd3);
    wait_state(3'd3);
    repeat (2999) @(negedge clock);
    expect_ev(3'd4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3000);
    expect_ev(3'd3, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1);
    press(4'd1);
    expect_ev(3'd4, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd3, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1);
    press(4'd2);
    expect_ev(3'd4, 4'd0, 5'd2, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd5, 4'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1);
    press(4'd4);

    // Round 5: button held from playback into ESPERA is not a move
    expect_playback(3, -1);
    start(5'd3);
    repeat (100) @(negedge clock);
    botoes = 4'd1;
    wait_state(3'd3);
    repeat (20) @(negedge clock);
    botoes = 4'd0;
    repeat (5) @(negedge clock);
    expect_ev(3'd4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 26);
    expect_ev(3'd3, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1);
    press(4'd1);
    expect_ev(3'd4, 4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 9);
    expect_ev(3'd5, 4'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1);
    press(4'd8);

    // Round 6: reset in the middle of MOSTRA_ON
    expect_ev(3'd1, pat[0], 5'd0, 1'b0, 1'b0, 1'b0, -1);
    expect_ev(3'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 101);
    start(5'd3);
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Invalid lengths must leave the engine idle (no transition expected)
    start(5'd0);
    start(5'd17);
    repeat (10) @(negedge clock);

    // Round 7: length 1; memory survives reset
    expect_playback(1, -1);
    start(5'd1);
    wait_state(3'd3);
    expect_ev(3'd4, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1);
    expect_ev(3'd5, 4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1);
    press(4'd1);

    repeat (5) @(negedge clock);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic [2:0] prev_st;
    int         cnt;
    int         ev;
    obs_t       e;
    prev_st = 3'b111;
    cnt     = 0;
    ev      = 0;
    forever begin
      @(negedge clock);
      if (done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expected transitions never seen, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end else if (!$isunknown(db_estado) && db_estado != prev_st) begin
        ev++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL event %0d unexpected: entered state %0d, required no transition",
                   ev, db_estado);
        end else begin
          e = q.pop_front();
          if (e.st !== db_estado || e.leds !== leds || e.acertos !== acertos ||
              e.jog !== jogando || e.pr !== pronto || e.ac !== acertou ||
              e.er !== errou || e.to !== timeout || (e.dwell >= 0 && e.dwell != cnt)) begin
            errors++;
            $display({"FAIL event %0d: got st=%0d leds=%h acertos=%0d jog=%b pr=%b ac=%b ",
                      "er=%b to=%b dwell=%0d; required st=%0d leds=%h acertos=%0d jog=%b ",
                      "pr=%b ac=%b er=%b to=%b dwell=%0d"},
                     ev, db_estado, leds, acertos, jogando, pronto, acertou, errou, timeout,
                     cnt, e.st, e.leds, e.acertos, e.jog, e.pr, e.ac, e.er, e.to, e.dwell);
          end
        end
        prev_st = db_estado;
        cnt     = 1;
      end else begin
        cnt++;
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
